multi_alarm_ctrl: RTL and testbench

Parametrised alarm engine holding NUM_ALARMS independent alarm entries, each with hour, minute and on/off.
- Compares the entries against the running time once per second.
- Rings for a bounded time and supports snooze and dismiss.
- Reports alarms that matched while another alarm was already active.
- Sits beside the time-keeping block and is driven by the 1 Hz enable. It replaces the single-alarm mode logic and feeds the mode/display layer through a read port.

---
 rtl/alarm_pkg.sv | 15 +
 rtl/alarm_match.sv | 46 ++++
 rtl/multi_alarm_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and field widths for the multi-entry alarm engine.
package alarm_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } alarm_state_t;

endpackage

// File: rtl/alarm_match.sv
// Combinational compare of the alarm table against the current time,
// producing the match mask and the lowest matching index.
module alarm_match
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                                tick,
  input  logic [7:0]                          hour,
  input  logic [7:0]                          minute,
  input  logic [7:0]                          second,
  input  logic [NUM_ALARMS-1:0][HOUR_W-1:0]   ent_hour,
  input  logic [NUM_ALARMS-1:0][MIN_W-1:0]    ent_min,
  input  logic [NUM_ALARMS-1:0]               ent_on,
  output logic [NUM_ALARMS-1:0]               match,
  output logic                                any_match,
  output logic [IDX_W-1:0]                    first_idx,
  output logic [NUM_ALARMS-1:0]               first_mask
);

  logic at_minute_start;

  assign at_minute_start = tick && (second == 8'd0);

  always_comb begin
    match      = '0;
    any_match  = 1'b0;
    first_idx  = '0;
    first_mask = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      // Out-of-range stored values are kept verbatim but must never fire.
      match[i] = at_minute_start && ent_on[i]
                 && (ent_hour[i] <= HOUR_W'(MAX_HOUR))
                 && (ent_min[i]  <= MIN_W'(MAX_MIN))
                 && (hour   == {{(8-HOUR_W){1'b0}}, ent_hour[i]})
                 && (minute == {{(8-MIN_W){1'b0}}, ent_min[i]});
      if (match[i] && !any_match) begin
        any_match     = 1'b1;
        first_idx     = IDX_W'(i);
        first_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-entry alarm engine: entry table, 1 Hz match, ring/snooze/stop FSM
// and sticky record of matches that arrived while already busy.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk1sec,
  input  logic [7:0]            hour,
  input  logic [7:0]            minute,
  input  logic [7:0]            second,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [4:0]            wr_hour,
  input  logic [5:0]            wr_min,
  input  logic                  wr_on,
  input  logic                  snooze,
  input  logic                  stop,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [4:0]            rd_hour,
  output logic [5:0]            rd_min,
  output logic                  rd_on,
  output logic                  ringing,
  output logic [IDX_W-1:0]      ring_idx,
  output logic                  snoozing,
  output logic [1:0]            snooze_left,
  output logic [NUM_ALARMS-1:0] missed
);

  localparam int unsigned RW = (RING_SECS   < 2) ? 1 : $clog2(RING_SECS + 1);
  localparam int unsigned SW = (SNOOZE_SECS < 2) ? 1 : $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_INIT    = 2'(MAX_SNOOZE);

  logic [NUM_ALARMS-1:0][HOUR_W-1:0] ent_hour;
  logic [NUM_ALARMS-1:0][MIN_W-1:0]  ent_min;
  logic [NUM_ALARMS-1:0]             ent_on;
  logic                              tick_d;

  alarm_state_t          state, state_n;
  logic [IDX_W-1:0]      ring_idx_n;
  logic [RW-1:0]         ring_cnt, ring_cnt_n;
  logic [SW-1:0]         snz_cnt, snz_cnt_n;
  logic [1:0]            snooze_left_n;
  logic [NUM_ALARMS-1:0] missed_n;

  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] first_mask;
  logic                  any_match;
  logic [IDX_W-1:0]      first_idx;
  logic                  kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_hour <= '0;
      ent_min  <= '0;
      ent_on   <= '0;
      tick_d   <= 1'b0;
    end else begin
      tick_d <= clk1sec;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          ent_hour[i] <= wr_hour;
          ent_min[i]  <= wr_min;
          ent_on[i]   <= wr_on;
        end
      end
    end
  end

  always_comb begin
    rd_hour = '0;
    rd_min  = '0;
    rd_on   = 1'b0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_hour = ent_hour[i];
        rd_min  = ent_min[i];
        rd_on   = ent_on[i];
      end
    end
  end

  alarm_match #(
    .NUM_ALARMS (NUM_ALARMS),
    .IDX_W      (IDX_W)
  ) u_match (
    .tick       (tick_d),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .ent_hour   (ent_hour),
    .ent_min    (ent_min),
    .ent_on     (ent_on),
    .match      (match),
    .any_match  (any_match),
    .first_idx  (first_idx),
    .first_mask (first_mask)
  );

  assign kill = wr_en && (wr_idx == ring_idx) && !wr_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ring_idx    <= '0;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      snooze_left <= SNZ_INIT;
      missed      <= '0;
    end else begin
      state       <= state_n;
      ring_idx    <= ring_idx_n;
      ring_cnt    <= ring_cnt_n;
      snz_cnt     <= snz_cnt_n;
      snooze_left <= snooze_left_n;
      missed      <= missed_n;
    end
  end

  always_comb begin
    state_n       = state;
    ring_idx_n    = ring_idx;
    ring_cnt_n    = ring_cnt;
    snz_cnt_n     = snz_cnt;
    snooze_left_n = snooze_left;
    missed_n      = stop ? '0 : missed;
    unique case (state)
      IDLE: begin
        if (any_match) begin
          state_n       = RING;
          ring_idx_n    = first_idx;
          ring_cnt_n    = '0;
          snooze_left_n = SNZ_INIT;
          missed_n      = missed_n | (match & ~first_mask);
        end
      end
      RING: begin
        // Busy: every fresh match is only recorded, including on the exit cycle.
        missed_n = missed_n | match;
        if (stop || kill) begin
          state_n = IDLE;
        end else if (snooze && (snooze_left != 2'd0)) begin
          state_n       = SNOOZE;
          snooze_left_n = snooze_left - 2'd1;
          snz_cnt_n     = '0;
        end else if (tick_d) begin
          if (ring_cnt == RING_LAST) begin
            state_n    = IDLE;
            ring_cnt_n = '0;
          end else begin
            ring_cnt_n = ring_cnt + RW'(1);
          end
        end
      end
      SNOOZE: begin
        missed_n = missed_n | match;
        if (stop || kill) begin
          state_n = IDLE;
        end else if (tick_d) begin
          if (snz_cnt == SNOOZE_LAST) begin
            state_n    = RING;
            ring_cnt_n = '0;
            snz_cnt_n  = '0;
          end else begin
            snz_cnt_n = snz_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed self-checking bench for multi_alarm_ctrl (RING_SECS=3, SNOOZE_SECS=2).
module tb_multi_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk1sec = 1'b0;
  logic [7:0] hour = '0, minute = '0, second = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [4:0] wr_hour = '0;
  logic [5:0] wr_min = '0;
  logic       wr_on = 1'b0;
  logic       snooze = 1'b0, stop = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [4:0] rd_hour;
  logic [5:0] rd_min;
  logic       rd_on, ringing, snoozing;
  logic [1:0] ring_idx, snooze_left;
  logic [3:0] missed;

  int n_checks = 0;
  int n_fail   = 0;

  multi_alarm_ctrl #(
    .NUM_ALARMS  (4),
    .IDX_W       (2),
    .RING_SECS   (3),
    .SNOOZE_SECS (2),
    .MAX_SNOOZE  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk1sec     (clk1sec),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_hour     (wr_hour),
    .wr_min      (wr_min),
    .wr_on       (wr_on),
    .snooze      (snooze),
    .stop        (stop),
    .rd_idx      (rd_idx),
    .rd_hour     (rd_hour),
    .rd_min      (rd_min),
    .rd_on       (rd_on),
    .ringing     (ringing),
    .ring_idx    (ring_idx),
    .snoozing    (snoozing),
    .snooze_left (snooze_left),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  // Drive a 1 Hz pulse with the given time; returns after the FSM edge.
  task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    hour = h; minute = m; second = s; clk1sec = 1'b1;
    @(negedge clk);
    clk1sec = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                    input logic on);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_hour = h; wr_min = m; wr_on = on;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic snz, input logic stp);
    @(negedge clk);
    snooze = snz; stop = stp;
    @(negedge clk);
    snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || ring_idx !== 2'd0 || missed !== 4'd0
        || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_outputs: ringing=%b snoozing=%b ring_idx=%0d missed=%b left=%0d, required 0 0 0 0000 3",
               ringing, snoozing, ring_idx, missed, snooze_left);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      n_checks++;
      if (rd_on !== 1'b0 || rd_hour !== 5'd0 || rd_min !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_entry%0d: %0d:%0d on=%b, required 0:0 on=0", i, rd_hour, rd_min, rd_on);
      end
    end
  endtask

  task automatic test_write_read;
    wr(2'd1, 5'd7, 6'd30, 1'b1);
    rd_idx = 2'd1;
    #1;
    n_checks++;
    if (rd_hour !== 5'd7 || rd_min !== 6'd30 || rd_on !== 1'b1) begin
      n_fail++;
      $display("FAIL write_read: %0d:%0d on=%b, required 7:30 on=1", rd_hour, rd_min, rd_on);
    end
    wr(2'd3, 5'd31, 6'd63, 1'b1);
    rd_idx = 2'd3;
    #1;
    n_checks++;
    if (rd_hour !== 5'd31 || rd_min !== 6'd63 || rd_on !== 1'b1) begin
      n_fail++;
      $display("FAIL write_unclamped: %0d:%0d on=%b, required 31:63 on=1", rd_hour, rd_min, rd_on);
    end
    tick(8'd31, 8'd63, 8'd0);
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL out_of_range_match: ringing=%b, required 0", ringing);
    end
    wr(2'd3, 5'd0, 6'd0, 1'b0);
  endtask

  task automatic test_basic_trigger;
    tick(8'd7, 8'd29, 8'd59);
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_match: ringing=%b, required 0", ringing);
    end
    @(negedge clk);
    hour = 8'd7; minute = 8'd30; second = 8'd0; clk1sec = 1'b1;
    @(negedge clk);
    clk1sec = 1'b0;
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_latency_1clk: ringing=%b, required 0", ringing);
    end
    @(negedge clk);
    n_checks++;
    if (ringing !== 1'b1 || ring_idx !== 2'd1 || missed !== 4'b0000) begin
      n_fail++;
      $display("FAIL ring_latency_2clk: ringing=%b idx=%0d missed=%b, required 1 1 0000",
               ringing, ring_idx, missed);
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_missed;
    wr(2'd0, 5'd6, 6'd0, 1'b1);
    wr(2'd2, 5'd6, 6'd0, 1'b1);
    tick(8'd6, 8'd0, 8'd0);
    n_checks++;
    if (ringing !== 1'b1 || ring_idx !== 2'd0 || missed !== 4'b0100) begin
      n_fail++;
      $display("FAIL multi_match: ringing=%b idx=%0d missed=%b, required 1 0 0100",
               ringing, ring_idx, missed);
    end
    pulse(1'b0, 1'b1);
    n_checks++;
    if (ringing !== 1'b0 || missed !== 4'b0000) begin
      n_fail++;
      $display("FAIL stop_clears: ringing=%b missed=%b, required 0 0000", ringing, missed);
    end
  endtask

  task automatic test_auto_stop;
    tick(8'd6, 8'd0, 8'd0);
    tick(8'd6, 8'd0, 8'd1);
    tick(8'd6, 8'd0, 8'd2);
    n_checks++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_stop_early: ringing=%b after 2 ticks, required 1", ringing);
    end
    tick(8'd6, 8'd0, 8'd3);
    n_checks++;
    if (ringing !== 1'b0 || missed !== 4'b0100) begin
      n_fail++;
      $display("FAIL auto_stop: ringing=%b missed=%b, required 0 0100", ringing, missed);
    end
    tick(8'd6, 8'd0, 8'd0);
    n_checks++;
    if (ringing !== 1'b1 || ring_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL next_day: ringing=%b idx=%0d, required 1 0", ringing, ring_idx);
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_snooze;
    logic [1:0] exp_left;
    tick(8'd7, 8'd30, 8'd0);
    n_checks++;
    if (ringing !== 1'b1 || ring_idx !== 2'd1 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL snooze_trigger: ringing=%b idx=%0d left=%0d, required 1 1 3",
               ringing, ring_idx, snooze_left);
    end
    exp_left = 2'd3;
    for (int k = 0; k < 3; k++) begin
      exp_left = exp_left - 2'd1;
      pulse(1'b1, 1'b0);
      n_checks++;
      if (snoozing !== 1'b1 || ringing !== 1'b0 || snooze_left !== exp_left) begin
        n_fail++;
        $display("FAIL snooze_%0d: snoozing=%b ringing=%b left=%0d, required 1 0 %0d",
                 k, snoozing, ringing, snooze_left, exp_left);
      end
      tick(8'd7, 8'd30, 8'(10 + k));
      n_checks++;
      if (snoozing !== 1'b1) begin
        n_fail++;
        $display("FAIL snooze_hold_%0d: snoozing=%b, required 1", k, snoozing);
      end
      tick(8'd7, 8'd30, 8'(20 + k));
      n_checks++;
      if (ringing !== 1'b1 || snoozing !== 1'b0 || ring_idx !== 2'd1) begin
        n_fail++;
        $display("FAIL rering_%0d: ringing=%b snoozing=%b idx=%0d, required 1 0 1",
                 k, ringing, snoozing, ring_idx);
      end
    end
    pulse(1'b1, 1'b0);
    n_checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_left !== 2'd0) begin
      n_fail++;
      $display("FAIL snooze_exhausted: ringing=%b snoozing=%b left=%0d, required 1 0 0",
               ringing, snoozing, snooze_left);
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_disable;
    tick(8'd7, 8'd30, 8'd0);
    wr(2'd1, 5'd7, 6'd30, 1'b1);
    n_checks++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL write_on_keeps: ringing=%b, required 1", ringing);
    end
    wr(2'd1, 5'd7, 6'd30, 1'b0);
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      n_fail++;
      $display("FAIL write_off_kills: ringing=%b snoozing=%b, required 0 0", ringing, snoozing);
    end
    wr(2'd1, 5'd7, 6'd30, 1'b1);
    tick(8'd7, 8'd30, 8'd0);
    pulse(1'b1, 1'b1);
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL stop_beats_snooze: ringing=%b snoozing=%b left=%0d, required 0 0 3",
               ringing, snoozing, snooze_left);
    end
  endtask

  task automatic test_reset_in_snooze;
    tick(8'd6, 8'd0, 8'd0);
    pulse(1'b1, 1'b0);
    n_checks++;
    if (snoozing !== 1'b1 || missed !== 4'b0100) begin
      n_fail++;
      $display("FAIL pre_reset_snooze: snoozing=%b missed=%b, required 1 0100", snoozing, missed);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || ring_idx !== 2'd0 || missed !== 4'd0
        || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_mid_snooze: ringing=%b snoozing=%b idx=%0d missed=%b left=%0d, required 0 0 0 0000 3",
               ringing, snoozing, ring_idx, missed, snooze_left);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      n_checks++;
      if (rd_on !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rd_on%0d: rd_on=%b, required 0", i, rd_on);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_basic_trigger;
    test_missed;
    test_auto_stop;
    test_snooze;
    test_disable;
    test_reset_in_snooze;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
